dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 data RAM between two requesters: port 0 is the core's load/store path, port 1 is the host/debug loader.
- Does round-robin arbitration with an optional per-requester lock, plus a starvation counter that bounds how long one port can hold the RAM.
- Sits between the core datapath and the data RAM; the RAM itself stays outside the block.

Parameters:
- DATA_W, 8, data width (matches the data RAM width).
- ADDR_W, 8, address width (256-entry RAM).
- MAX_HOLD, 4, maximum consecutive grants to one port while the other port is requesting; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i[2]  in  2  access request, one bit per port.
- we_i[2]  in  2  write enable, one bit per port.
- lock_i[2]  in  2  keep grant after this access, one bit per port.
- addr_i[2]  in  2xADDR_W  address, per port.
- wdata_i[2]  in  2xDATA_W  write data, per port.
- gnt_o[2]  out  2  grant, combinational, one-hot or zero.
- rvalid_o[2]  out  2  read data valid, one bit per port.
- rdata_o  out  DATA_W  read data, shared by both ports.
- mem_en_o  out  1  RAM access strobe.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_rdata_i  in  DATA_W  RAM read data, valid one cycle after mem_en_o with mem_we_o low.

Behaviour:
- Handshake:
  - An access completes in a cycle where req_i[n] and gnt_o[n] are both 1.
  - In that cycle mem_en_o=1, and mem_we_o, mem_addr_o, mem_wdata_o are muxed from port n.
  - A requester holds addr/we/wdata stable until it is granted.
- Reads:
  - rvalid_o[n]=1 exactly one cycle after a granted read by port n.
  - rdata_o = mem_rdata_i in that cycle. It is undefined when no rvalid_o bit is set.
- Writes: no response.
- Throughput: one access per cycle; back-to-back grants to the same or alternating ports are allowed.
- State machine, states OPEN, HELD0, HELD1 (reset state OPEN):
  - OPEN: if only one port requests, that port is granted. If both request, the port != last_gnt is granted (round-robin). last_gnt resets to 1, so port 0 wins the first tie.
  - OPEN -> HELDn when port n is granted with lock_i[n]=1.
  - HELDn: gnt_o[n] = req_i[n]; the other port gets no grant.
  - HELDn -> OPEN on a granted access by port n with lock_i[n]=0, or when req_i[n]=0 for a cycle.
- Starvation counter hold_cnt (4 bits):
  - Increments on each grant to the same port as the previous grant while the other port is requesting.
  - Resets to 0 on a grant switch or when the other port is idle.
- Starvation override:
  - When hold_cnt == MAX_HOLD, the other port wins the next contended cycle, even if the current port is in HELD.
  - The state then returns to OPEN and the lock is broken. The lock owner must re-request.
- Write then read to the same address on consecutive cycles returns the new data; this is the RAM's write-first behaviour and is passed through unchanged.
- Simultaneous read by port 0 and write by port 1 to the same address: the winner goes first and the loser is served later, so ordering follows grant order.
- Reset (asynchronous, any time):
  - state=OPEN, last_gnt=1, hold_cnt=0.
  - rvalid_o=0, rdata_o=0, gnt_o=0, mem_en_o=0, mem_we_o=0.
  - A read in flight is dropped and no rvalid is produced after reset.
- Widths: address and data pass through unchanged; no arithmetic on the datapath. hold_cnt saturates at MAX_HOLD.

Decomposition:
- Shared package dmem_pkg:
  - data_t and addr_t typedefs.
  - The arb_state_t enum {OPEN, HELD0, HELD1}.
  - DATAMEM_DEPTH = 256.
- Sub-module rr_pick2: a purely combinational 2-way round-robin picker (req[1:0], last, force -> one-hot gnt). The state register, counter and muxes stay in dmem_arbiter.

Test Plan:
- Single requester: port 0 reads addr 0x05 with RAM[5]=0x0F -> gnt_o=01 in the same cycle, rvalid_o=01 and rdata_o=0x0F next cycle, mem_we_o=0.
- Tie after reset: both ports request continuously with no locks -> grants alternate 01,10,01,10; rvalid tracks the correct port each cycle.
- Lock: port 1 writes 0x10..0x13 with lock=1 while port 0 requests, MAX_HOLD=4 -> port 1 gets 4 grants, then port 0 is forced a grant on cycle 5 and state=OPEN.
- Lock release: port 0 locks, port 0 then drops req for one cycle -> port 1 is granted the next cycle and hold_cnt=0.
- Write/read ordering: port 1 writes 0xAA to 0x20, port 0 reads 0x20 on the following cycle -> rdata_o=0xAA.
- Reset mid-read: assert rst_n=0 in the cycle after a granted read -> rvalid_o stays 0, all outputs are at reset values, and the first post-reset tie goes to port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-RAM arbiter: datapath widths, RAM depth and arbiter states.
package dmem_pkg;

   localparam int DATAMEM_DEPTH = 256;
   localparam int DMEM_DATA_W   = 8;
   localparam int DMEM_ADDR_W   = 8;

   typedef logic [DMEM_DATA_W-1:0] data_t;
   typedef logic [DMEM_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      OPEN  = 2'd0,
      HELD0 = 2'd1,
      HELD1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie or a forced turn goes to the port that was not granted last.
module rr_pick2
   import dmem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic       i_force,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_force || (&i_req))
         o_gnt = i_last ? {1'b0, i_req[0]} : {i_req[1], 1'b0};
      else
         o_gnt = i_req;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core (port 0) and the
// host loader (port 1), with per-port lock and a starvation bound on consecutive grants.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_i,
   input  logic [1:0]             we_i,
   input  logic [1:0]             lock_i,
   input  logic [1:0][ADDR_W-1:0] addr_i,
   input  logic [1:0][DATA_W-1:0] wdata_i,
   output logic [1:0]             gnt_o,
   output logic [1:0]             rvalid_o,
   output logic [DATA_W-1:0]      rdata_o,
   output logic                   mem_en_o,
   output logic                   mem_we_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic [DATA_W-1:0]      mem_wdata_o,
   input  logic [DATA_W-1:0]      mem_rdata_i
);

   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

   arb_state_t r_state;
   logic       r_last;
   logic [3:0] r_hold_cnt;
   logic [1:0] r_rvalid_p1;

   logic       w_force;
   logic [1:0] w_pick;
   logic [1:0] w_gnt;
   logic       w_any;
   logic       w_idx;
   logic [3:0] w_cnt_base;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= HOLD_LIM) ? HOLD_LIM : v + 4'd1;
   endfunction

   // The port that has waited through MAX_HOLD grants wins the next contended cycle.
   assign w_force = (r_hold_cnt == HOLD_LIM) && (&req_i);

   rr_pick2 u_pick (
      .i_req   (req_i),
      .i_last  (r_last),
      .i_force (w_force),
      .o_gnt   (w_pick)
   );

   always_comb begin
      w_gnt = w_pick;
      if (!w_force) begin
         case (r_state)
            HELD0:   w_gnt = {1'b0, req_i[0]};
            HELD1:   w_gnt = {req_i[1], 1'b0};
            default: w_gnt = w_pick;
         endcase
      end
      if (!rst_n)
         w_gnt = 2'b00;
   end

   assign w_any       = |w_gnt;
   assign w_idx       = w_gnt[1];
   assign gnt_o       = w_gnt;
   assign mem_en_o    = w_any;
   assign mem_we_o    = w_any & we_i[w_idx];
   assign mem_addr_o  = addr_i[w_idx];
   assign mem_wdata_o = wdata_i[w_idx];
   assign rvalid_o    = r_rvalid_p1;
   assign rdata_o     = (|r_rvalid_p1) ? mem_rdata_i : '0;
   // A grant switch restarts the run; the grant itself still counts when contended.
   assign w_cnt_base  = (w_idx == r_last) ? r_hold_cnt : 4'd0;

   // p0 -> p1: RAM read response aligns with rvalid one cycle after the grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= OPEN;
         r_last      <= 1'b1;
         r_hold_cnt  <= 4'd0;
         r_rvalid_p1 <= 2'b00;
      end else begin
         r_rvalid_p1 <= w_gnt & ~we_i;

         if (w_any) begin
            r_last     <= w_idx;
            r_hold_cnt <= req_i[!w_idx] ? sat_inc(w_cnt_base) : 4'd0;
         end else if (!req_i[!r_last]) begin
            r_hold_cnt <= 4'd0;
         end

         if (w_force) begin
            r_state <= OPEN;
         end else begin
            case (r_state)
               OPEN:    if (w_any && lock_i[w_idx]) r_state <= w_idx ? HELD1 : HELD0;
               HELD0:   if (!req_i[0] || !lock_i[0]) r_state <= OPEN;
               HELD1:   if (!req_i[1] || !lock_i[1]) r_state <= OPEN;
               default: r_state <= OPEN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MAXH = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req, we, lock;
   logic [1:0][7:0] addr, wdata;
   logic [1:0]      gnt, rvalid;
   logic [7:0]      rdata;
   logic            mem_en, mem_we;
   logic [7:0]      mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   data_t ram [DATAMEM_DEPTH];
   data_t shadow [DATAMEM_DEPTH];
   data_t ram_q;
   bit    ram_ready;

   int         m_owner, m_last, m_run;
   logic [1:0] exp_rv;
   data_t      exp_rd;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_HOLD(MAXH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req),
      .we_i        (we),
      .lock_i      (lock),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   assign mem_rdata = ram_q;

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < DATAMEM_DEPTH; i++) ram[i] <= data_t'(i) ^ 8'h0A;
         ram_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_q <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 1;
      m_run   = 0;
      exp_rv  = 2'b00;
      exp_rd  = 8'h00;
   endtask

   // One clock: check the DUT at the falling edge against the model, then advance the model.
   task automatic cycle(output logic [1:0] g_obs);
      int         g;
      bit         forced;
      logic [1:0] exp_g;
      @(negedge clk);
      forced = req[0] && req[1] && (m_run >= MAXH);
      if (forced)             g = 1 - m_last;
      else if (m_owner >= 0)  g = req[m_owner] ? m_owner : -1;
      else if (req == 2'b11)  g = 1 - m_last;
      else if (req[0])        g = 0;
      else if (req[1])        g = 1;
      else                    g = -1;
      exp_g = (g < 0) ? 2'b00 : 2'(1 << g);

      chk("gnt", gnt, exp_g);
      chk("mem_en", mem_en, (g >= 0));
      if (g >= 0) begin
         chk("mem_we", mem_we, we[g]);
         chk("mem_addr", mem_addr, addr[g]);
         if (we[g]) chk("mem_wdata", mem_wdata, wdata[g]);
      end
      chk("rvalid", rvalid, exp_rv);
      if (exp_rv != 2'b00) chk("rdata", rdata, exp_rd);
      g_obs = gnt;

      if (forced)                 m_owner = -1;
      else if (m_owner >= 0) begin
         if (!req[m_owner] || !lock[m_owner]) m_owner = -1;
      end else if (g >= 0 && lock[g]) m_owner = g;

      if (g >= 0) begin
         if (!req[1-g])         m_run = 0;
         else if (g == m_last)  m_run = (m_run >= MAXH) ? MAXH : m_run + 1;
         else                   m_run = 1;
         if (we[g]) begin
            shadow[addr[g]] = wdata[g];
            exp_rv = 2'b00;
         end else begin
            exp_rv = 2'(1 << g);
            exp_rd = shadow[addr[g]];
         end
         m_last = g;
      end else begin
         exp_rv = 2'b00;
         if (!req[1-m_last]) m_run = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] g;
      logic [1:0] pend;
      for (int i = 0; i < DATAMEM_DEPTH; i++) shadow[i] = data_t'(i) ^ 8'h0A;
      rst_n = 1'b0;
      req   = 2'b11;
      we    = 2'b00;
      lock  = 2'b00;
      addr  = '0;
      wdata = '0;
      model_reset();

      // Reset values, with both requests asserted to show the grant is held off
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_rvalid", rvalid, 2'b00);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      rst_n = 1'b1;

      // Tie after reset alternates starting with port 0
      addr[0] = 8'h01;
      addr[1] = 8'h02;
      for (int i = 0; i < 4; i++) begin
         cycle(g);
         chk("tie_gnt", g, (i % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Single requester read
      req     = 2'b01;
      addr[0] = 8'h05;
      cycle(g);
      chk("single_gnt", g, 2'b01);
      req = 2'b00;
      chk("single_rvalid", rvalid, 2'b01);
      chk("single_rdata", rdata, 8'h0F);
      cycle(g);

      // Locked writer is cut off after MAX_HOLD contended grants
      req     = 2'b11;
      we      = 2'b10;
      lock    = 2'b10;
      addr[0] = 8'h11;
      for (int i = 0; i < 5; i++) begin
         addr[1]  = 8'h10 + 8'(i);
         wdata[1] = 8'hC0 + 8'(i);
         cycle(g);
         chk("lock_gnt", g, (i < 4) ? 2'b10 : 2'b01);
      end
      chk("lock_rdata", rdata, 8'hC1);
      req     = 2'b01;
      addr[0] = 8'h12;
      cycle(g);
      chk("lock_broken", g, 2'b01);
      req  = 2'b10;
      lock = 2'b00;
      cycle(g);
      chk("lock_rereq", g, 2'b10);

      // Port 0 lock released by dropping its request
      req     = 2'b11;
      we      = 2'b00;
      lock    = 2'b01;
      addr[0] = 8'h30;
      addr[1] = 8'h31;
      cycle(g);
      chk("rel_first", g, 2'b01);
      cycle(g);
      chk("rel_held", g, 2'b01);
      req = 2'b10;
      cycle(g);
      chk("rel_drop", g, 2'b00);
      cycle(g);
      chk("rel_other", g, 2'b10);
      req  = 2'b00;
      lock = 2'b00;
      cycle(g);

      // Write then read of the same address
      req      = 2'b10;
      we       = 2'b10;
      addr[1]  = 8'h20;
      wdata[1] = 8'hAA;
      cycle(g);
      req     = 2'b01;
      we      = 2'b00;
      addr[0] = 8'h20;
      cycle(g);
      chk("wr_rd_rdata", rdata, 8'hAA);

      // Contended read/write to one address follows grant order
      req      = 2'b11;
      we       = 2'b10;
      wdata[1] = 8'h55;
      cycle(g);
      chk("order_first", g, 2'b10);
      req = 2'b01;
      we  = 2'b00;
      cycle(g);
      chk("order_second", g, 2'b01);
      chk("order_rdata", rdata, 8'h55);

      // Reset while a read response is due
      addr[0] = 8'h05;
      cycle(g);
      rst_n = 1'b0;
      req   = 2'b11;
      #1;
      model_reset();
      chk("mrst_rvalid", rvalid, 2'b00);
      chk("mrst_gnt", gnt, 2'b00);
      chk("mrst_rdata", rdata, 8'h00);
      chk("mrst_mem_en", mem_en, 1'b0);
      chk("mrst_mem_we", mem_we, 1'b0);
      @(posedge clk);
      #1;
      chk("mrst_rvalid_hold", rvalid, 2'b00);
      rst_n = 1'b1;
      cycle(g);
      chk("mrst_tie", g, 2'b01);

      // Random traffic; each port holds its transaction until granted
      req  = 2'b00;
      pend = 2'b00;
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(0, 9) < 8)) begin
               pend[p]  = 1'b1;
               we[p]    = 1'($urandom_range(0, 1));
               lock[p]  = 1'($urandom_range(0, 1));
               addr[p]  = 8'($urandom_range(0, 15));
               wdata[p] = 8'($urandom);
            end
         end
         req = pend;
         cycle(g);
         pend = pend & ~g;
      end
      req = 2'b00;
      cycle(g);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
